// File: rtl/time12_ampm_core.sv
// ============================================================================
// Module   : time12_ampm_core
// Brief    : 12-hour time-of-day counter with AM/PM flag, 1 Hz advance,
//            set-mode button edits and a midnight pulse. Optional hr24 output
//            is enabled with the HR24_OUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time12_ampm_core #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_1hz_i,
    input  logic [1:0] mode_i,
    input  logic       inc_min_btn_i,
    input  logic       inc_hr_btn_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [3:0] hr12_o,
    output logic       ap_o,
`ifdef HR24_OUT_EN
    output logic [4:0] hr24_o,
`endif
    output logic       midnight_o
);

    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [1:0]      MODE_SET = 2'b10;

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [3:0]    hr_q, hr_d;
    logic          ap_q, ap_d;
    logic          mid_q, mid_d;
    logic [1:0]    mode_prev_q;
    logic          btn_min_q, btn_hr_q;

    logic          w_set;
    logic          w_min_edge;
    logic          w_hr_edge;
    logic          w_adv;
    logic [4:0]    w_hr_inc;

    // Returns {ap, hr}; out-of-range hours land on 12 without touching ap.
    function automatic logic [4:0] hr_next(input logic [3:0] h, input logic a);
        logic [4:0] r;
        r = {a, 4'd12};
        if (h == 4'd11)
            r = {~a, 4'd12};
        else if (h == 4'd12)
            r = {a, 4'd1};
        else if (h != 4'd0 && h < 4'd12)
            r = {a, h + 4'd1};
        return r;
    endfunction

    assign w_set      = (mode_i == MODE_SET);
    assign w_min_edge = inc_min_btn_i & ~btn_min_q;
    assign w_hr_edge  = inc_hr_btn_i & ~btn_hr_q;
    assign w_adv      = tick_1hz_i && (pre_q >= PRE_LAST);
    assign w_hr_inc   = hr_next(hr_q, ap_q);

    always_comb begin
        pre_d = pre_q;
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        ap_d  = ap_q;
        mid_d = 1'b0;
        if (w_set) begin
            if (mode_prev_q != MODE_SET)
                sec_d = 6'd0;
            if (w_min_edge)
                min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            if (w_hr_edge)
                {ap_d, hr_d} = w_hr_inc;
        end else if (tick_1hz_i) begin
            pre_d = w_adv ? '0 : pre_q + PW'(1);
            if (w_adv) begin
                if (sec_q >= 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q >= 6'd59) begin
                        min_d        = 6'd0;
                        {ap_d, hr_d} = w_hr_inc;
                        // Only the 11 PM carry lands on 12 AM.
                        mid_d        = (hr_q == 4'd11) && ap_q;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pre_q       <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hr_q        <= 4'd12;
            ap_q        <= 1'b0;
            mid_q       <= 1'b0;
            mode_prev_q <= 2'b00;
            btn_min_q   <= 1'b0;
            btn_hr_q    <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hr_q        <= hr_d;
            ap_q        <= ap_d;
            mid_q       <= mid_d;
            mode_prev_q <= mode_i;
            btn_min_q   <= inc_min_btn_i;
            btn_hr_q    <= inc_hr_btn_i;
        end
    end

    assign sec_o      = sec_q;
    assign min_o      = min_q;
    assign hr12_o     = hr_q;
    assign ap_o       = ap_q;
    assign midnight_o = mid_q;

`ifdef HR24_OUT_EN
    logic [4:0] w_hr_base;

    always_comb begin
        w_hr_base = {1'b0, hr_q};
        if (hr_q == 4'd0 || hr_q >= 4'd12)
            w_hr_base = 5'd0;
        hr24_o = ap_q ? w_hr_base + 5'd12 : w_hr_base;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_time12_ampm_core.sv
// ============================================================================
// Module   : tb_time12_ampm_core
// Brief    : Directed bench; a seconds-of-day model checks two DUTs (TICK_DIV
//            1 and 3) every cycle, plus literal checks at key points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time12_ampm_core;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [1:0] mode;
    logic       inc_min;
    logic       inc_hr;

    logic [5:0] sec_a, min_a, sec_b, min_b;
    logic [3:0] hr_a, hr_b;
    logic       ap_a, ap_b, mid_a, mid_b;
`ifdef HR24_OUT_EN
    logic [4:0] h24_a, h24_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    time12_ampm_core #(.TICK_DIV(1)) u_dut (
        .clk_i(clk), .reset_i(reset), .tick_1hz_i(tick), .mode_i(mode),
        .inc_min_btn_i(inc_min), .inc_hr_btn_i(inc_hr),
        .sec_o(sec_a), .min_o(min_a), .hr12_o(hr_a), .ap_o(ap_a),
`ifdef HR24_OUT_EN
        .hr24_o(h24_a),
`endif
        .midnight_o(mid_a)
    );

    time12_ampm_core #(.TICK_DIV(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .tick_1hz_i(tick), .mode_i(mode),
        .inc_min_btn_i(inc_min), .inc_hr_btn_i(inc_hr),
        .sec_o(sec_b), .min_o(min_b), .hr12_o(hr_b), .ap_o(ap_b),
`ifdef HR24_OUT_EN
        .hr24_o(h24_b),
`endif
        .midnight_o(mid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: time held as seconds since midnight, per DUT (index 0: div 1, 1: div 3).
    int t_m[2];
    int pc_m[2];
    bit mid_m[2];
    int div_m[2] = '{1, 3};
    int pmode_m;
    bit pbm_m, pbh_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                t_m[k]   <= 0;
                pc_m[k]  <= 0;
                mid_m[k] <= 1'b0;
            end
            pmode_m <= 0;
            pbm_m   <= 1'b0;
            pbh_m   <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int h, m, s, p, t;
                t = t_m[k];
                p = pc_m[k];
                mid_m[k] <= 1'b0;
                if (mode == 2'b10) begin
                    h = t / 3600; m = (t / 60) % 60; s = t % 60;
                    if (pmode_m != 2) s = 0;
                    if (inc_min && !pbm_m) m = (m + 1) % 60;
                    if (inc_hr && !pbh_m) h = (h + 1) % 24;
                    t_m[k] <= h * 3600 + m * 60 + s;
                end else if (tick) begin
                    p = (p + 1) % div_m[k];
                    pc_m[k] <= p;
                    if (p == 0) begin
                        t = (t + 1) % 86400;
                        t_m[k]   <= t;
                        mid_m[k] <= (t == 0);
                    end
                end
            end
            pmode_m <= int'(mode);
            pbm_m   <= inc_min;
            pbh_m   <= inc_hr;
        end
    end

    function automatic int e_hr12(int t);
        int h = (t / 3600) % 12;
        return (h == 0) ? 12 : h;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_sec",  int'(sec_a), t_m[0] % 60);
            chk("m_min",  int'(min_a), (t_m[0] / 60) % 60);
            chk("m_hr12", int'(hr_a),  e_hr12(t_m[0]));
            chk("m_ap",   int'(ap_a),  int'(t_m[0] >= 43200));
            chk("m_mid",  int'(mid_a), int'(mid_m[0]));
            chk("m3_sec", int'(sec_b), t_m[1] % 60);
            chk("m3_min", int'(min_b), (t_m[1] / 60) % 60);
            chk("m3_hr12", int'(hr_b), e_hr12(t_m[1]));
            chk("m3_ap",  int'(ap_b),  int'(t_m[1] >= 43200));
            chk("m3_mid", int'(mid_b), int'(mid_m[1]));
`ifdef HR24_OUT_EN
            chk("m_hr24",  int'(h24_a), t_m[0] / 3600);
            chk("m3_hr24", int'(h24_b), t_m[1] / 3600);
`endif
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick(int n);
        repeat (n) begin tick = 1'b1; step(1); tick = 1'b0; step(1); end
    endtask

    task automatic press_hr(int n);
        repeat (n) begin inc_hr = 1'b1; step(1); inc_hr = 1'b0; step(1); end
    endtask

    task automatic press_min(int n);
        repeat (n) begin inc_min = 1'b1; step(1); inc_min = 1'b0; step(1); end
    endtask

    task automatic chk_time(string nm, int h, int m, int s, int a);
        chk({nm, "_hr"},  int'(hr_a),  h);
        chk({nm, "_min"}, int'(min_a), m);
        chk({nm, "_sec"}, int'(sec_a), s);
        chk({nm, "_ap"},  int'(ap_a),  a);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; mode = 2'b01; inc_min = 1'b0; inc_hr = 1'b0;
        step(1);
        cmp_en = 1'b1;
        step(1);
        reset = 1'b0;
        chk_time("rst", 12, 0, 0, 0);
        chk("rst_mid", int'(mid_a), 0);
`ifdef HR24_OUT_EN
        chk("rst_hr24", int'(h24_a), 0);
`endif

        // Preload 11:59:59 AM, then roll into noon in 12h view.
        mode = 2'b10; press_hr(11); press_min(59);
        mode = 2'b01; pulse_tick(59);
        chk_time("pre_noon", 11, 59, 59, 0);
        tick = 1'b1; step(1);
        chk_time("noon", 12, 0, 0, 1);
        chk("noon_mid", int'(mid_a), 0);
        tick = 1'b0; step(1);

        // 11:59:59 PM -> midnight in 24h view.
        mode = 2'b10; press_hr(11); press_min(59);
        mode = 2'b00; pulse_tick(59);
        chk_time("pre_mid", 11, 59, 59, 1);
        tick = 1'b1; step(1);
        chk_time("midn", 12, 0, 0, 0);
        chk("midn_pulse", int'(mid_a), 1);
        tick = 1'b0; step(1);
        chk("midn_gone", int'(mid_a), 0);

        // Set-mode entry clears seconds; ticks are frozen out.
        pulse_tick(37);
        chk("sec37", int'(sec_a), 37);
        mode = 2'b10; step(1);
        chk("set_clr", int'(sec_a), 0);
        pulse_tick(20);
        chk_time("frozen", 12, 0, 0, 0);
        inc_hr = 1'b1; step(50); inc_hr = 1'b0; step(1);
        chk("hold_hr", int'(hr_a), 1);
        press_min(59);
        chk("min59", int'(min_a), 59);
        press_min(1);
        chk_time("min_wrap", 1, 0, 0, 0);

        // 11 PM -> 12 AM by button: no midnight pulse.
        press_hr(22);
        chk_time("h23", 11, 0, 0, 1);
        inc_hr = 1'b1; step(1);
        chk_time("set_midn", 12, 0, 0, 0);
        chk("set_nomid", int'(mid_a), 0);
`ifdef HR24_OUT_EN
        chk("hr24_0", int'(h24_a), 0);
`endif
        inc_hr = 1'b0; step(1);
        inc_hr = 1'b1; inc_min = 1'b1; step(1);
        chk_time("both", 1, 1, 0, 0);
        inc_hr = 1'b0; inc_min = 1'b0; step(1);

        // Presses in run mode, or held across entry, must not fire.
        mode = 2'b11; press_hr(1);
        mode = 2'b10; step(2);
        mode = 2'b01; inc_hr = 1'b1; step(2);
        mode = 2'b10; step(3);
        chk("no_late", int'(hr_a), 1);
        inc_hr = 1'b0; step(1);

        // Prescaler divide-by-3 and hold across set mode.
        reset = 1'b1; step(1); reset = 1'b0;
        mode = 2'b01; pulse_tick(6);
        chk("div3_sec", int'(sec_b), 2);
        chk("div1_sec", int'(sec_a), 6);
        pulse_tick(2);
        mode = 2'b10; step(1); pulse_tick(5);
        mode = 2'b01; step(1); pulse_tick(1);
        chk("div3_hold", int'(sec_b), 1);

        // 3 PM, then 07:42:15 PM, then asynchronous reset mid-cycle.
        reset = 1'b1; step(1); reset = 1'b0;
        mode = 2'b10; press_hr(15);
        chk("pm3_hr", int'(hr_a), 3);
        chk("pm3_ap", int'(ap_a), 1);
`ifdef HR24_OUT_EN
        chk("hr24_15", int'(h24_a), 15);
`endif
        press_hr(4); press_min(42);
        mode = 2'b00; pulse_tick(15);
        chk_time("t1942", 7, 42, 15, 1);
        #2 reset = 1'b1;
        #1;
        chk_time("async", 12, 0, 0, 0);
        chk("async_mid", int'(mid_a), 0);
        chk("async3_hr", int'(hr_b), 12);
        @(negedge clk);
        reset = 1'b0;
        step(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
